// File: rtl/svc_rv_stage_pc.sv
// Program-counter stage: holds the fetch PC and selects next-PC from redirect, held redirect, BTB/RAS or sequential.
// Optional redirect/prediction counters are built when SVC_RV_PC_STATS_EN is defined.
module svc_rv_stage_pc #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int                BPRED    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_tgt,
    input  logic            btb_hit_if,
    input  logic            btb_pred_taken_if,
    input  logic [XLEN-1:0] btb_tgt_if,
    input  logic            btb_is_return_if,
    input  logic            ras_valid_if,
    input  logic [XLEN-1:0] ras_tgt_if,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            valid_if,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     pred_cnt
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            first_fetch_q, first_fetch_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            pred_taken;
    logic [XLEN-1:0] pred_tgt;
    logic [XLEN-1:0] pc_next_c;

    assign pred_taken = (BPRED != 0) && valid_q && btb_hit_if && btb_pred_taken_if;
    assign pred_tgt   = (btb_is_return_if && ras_valid_if) ? ras_tgt_if : btb_tgt_if;

    // Redirects outrank everything, including the first-fetch hold and predictions.
    always_comb begin
        if (redirect_valid) begin
            pc_next_c = redirect_tgt;
        end else if (pend_valid_q) begin
            pc_next_c = pend_tgt_q;
        end else if ((BPRED != 0) && first_fetch_q) begin
            pc_next_c = pc_q;
        end else if (pred_taken) begin
            pc_next_c = pred_tgt;
        end else begin
            pc_next_c = pc_q + PC_STEP;
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        pc_d          = pc_q;
        valid_d       = 1'b1;
        first_fetch_d = first_fetch_q;
        pend_valid_d  = pend_valid_q;
        pend_tgt_d    = pend_tgt_q;

        if (advance) begin
            pc_d         = pc_next_c;
            pend_valid_d = 1'b0;
            if (valid_q) begin
                first_fetch_d = 1'b0;
            end
        end else if (redirect_valid) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = redirect_tgt;
        end
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            valid_q       <= 1'b0;
            first_fetch_q <= 1'b1;
            pend_valid_q  <= 1'b0;
            pend_tgt_q    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
            pc_q          <= pc_d;
            valid_q       <= valid_d;
            first_fetch_q <= first_fetch_d;
            pend_valid_q  <= pend_valid_d;
            pend_tgt_q    <= pend_tgt_d;
        end
    end

`ifdef SVC_RV_PC_STATS_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] pred_cnt_q, pred_cnt_d;
    logic        pred_sel;

    // A prediction counts only when nothing of higher priority took the slot.
    assign pred_sel = pred_taken && !redirect_valid && !pend_valid_q && !first_fetch_q;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        pred_cnt_d     = pred_cnt_q;
        if (advance && (redirect_valid || pend_valid_q)) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end
        if (advance && pred_sel) begin
            pred_cnt_d = pred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
            pred_cnt_q     <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            pred_cnt_q     <= pred_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign pred_cnt     = pred_cnt_q;
`else
    assign redirect_cnt = '0;
    assign pred_cnt     = '0;
`endif

    assign pc       = pc_q;
    assign pc_next  = pc_next_c;
    assign valid_if = valid_q;

endmodule

// File: tb/tb_svc_rv_stage_pc.sv
// Directed bench for svc_rv_stage_pc: one predicting instance and one BPRED=0 instance at the top of the address space.
module tb_svc_rv_stage_pc;

`ifdef SVC_RV_PC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Predicting instance
    logic        rst_n, advance, redirect_valid;
    logic [31:0] redirect_tgt;
    logic        btb_hit, btb_taken, btb_ret, ras_valid;
    logic [31:0] btb_tgt, ras_tgt;
    logic [31:0] pc, pc_next, redirect_cnt, pred_cnt;
    logic        valid_if;

    // Non-predicting instance
    logic        rst_n2, advance2;
    logic        btb_hit2, btb_taken2, btb_ret2, ras_valid2;
    logic [31:0] btb_tgt2, ras_tgt2;
    logic [31:0] pc2, pc_next2, redirect_cnt2, pred_cnt2;
    logic        valid_if2;

    int n_checks = 0;
    int n_errors = 0;

    svc_rv_stage_pc #(.XLEN(32), .RESET_PC(32'h0000_0100), .BPRED(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .advance(advance),
        .redirect_valid(redirect_valid), .redirect_tgt(redirect_tgt),
        .btb_hit_if(btb_hit), .btb_pred_taken_if(btb_taken), .btb_tgt_if(btb_tgt),
        .btb_is_return_if(btb_ret), .ras_valid_if(ras_valid), .ras_tgt_if(ras_tgt),
        .pc(pc), .pc_next(pc_next), .valid_if(valid_if),
        .redirect_cnt(redirect_cnt), .pred_cnt(pred_cnt)
    );

    svc_rv_stage_pc #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .BPRED(0)) u_dut_nopred (
        .clk(clk), .rst_n(rst_n2), .advance(advance2),
        .redirect_valid(1'b0), .redirect_tgt(32'h0),
        .btb_hit_if(btb_hit2), .btb_pred_taken_if(btb_taken2), .btb_tgt_if(btb_tgt2),
        .btb_is_return_if(btb_ret2), .ras_valid_if(ras_valid2), .ras_tgt_if(ras_tgt2),
        .pc(pc2), .pc_next(pc_next2), .valid_if(valid_if2),
        .redirect_cnt(redirect_cnt2), .pred_cnt(pred_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_btb();
        btb_hit = 1'b0; btb_taken = 1'b0; btb_ret = 1'b0; ras_valid = 1'b0;
        btb_tgt = 32'h0; ras_tgt = 32'h0;
    endtask

    task automatic rand_btb2();
        btb_hit2 = 1'($urandom); btb_taken2 = 1'($urandom);
        btb_ret2 = 1'($urandom); ras_valid2 = 1'($urandom);
        btb_tgt2 = $urandom; ras_tgt2 = $urandom;
    endtask

    initial begin
        rst_n = 1'b0; advance = 1'b1; redirect_valid = 1'b0; redirect_tgt = 32'h0;
        clear_btb();
        rst_n2 = 1'b0; advance2 = 1'b0;
        rand_btb2();

        tick();
        tick();
        check("rst_pc", pc, 32'h100);
        check("rst_valid", {31'b0, valid_if}, 32'h0);
        check("rst_redirect_cnt", redirect_cnt, 32'h0);
        check("rst_pred_cnt", pred_cnt, 32'h0);

        // Reset release: first early fetch addresses RESET_PC
        rst_n = 1'b1;
        tick();
        check("rel_valid", {31'b0, valid_if}, 32'h1);
        check("rel_pc", pc, 32'h100);
        check("rel_pc_next", pc_next, 32'h100);
        tick();
        check("seq0_pc", pc, 32'h100);
        check("seq0_pc_next", pc_next, 32'h104);
        tick();
        check("seq1_pc", pc, 32'h104);
        check("seq1_pc_next", pc_next, 32'h108);
        tick();
        check("seq2_pc", pc, 32'h108);

        // BTB taken hit
        btb_hit = 1'b1; btb_taken = 1'b1; btb_tgt = 32'h200;
        #1;
        check("btb_pc_next", pc_next, 32'h200);
        tick();
        clear_btb();
        #1;
        check("btb_pc", pc, 32'h200);
        check("btb_pred_cnt", pred_cnt, STATS ? 32'd1 : 32'd0);
        check("btb_redirect_cnt", redirect_cnt, 32'd0);

        // Not-taken hit behaves sequentially
        btb_hit = 1'b1; btb_taken = 1'b0; btb_tgt = 32'h900;
        #1;
        check("btb_nt_pc_next", pc_next, 32'h204);

        // Return hit: RAS wins when valid, BTB target otherwise
        btb_hit = 1'b1; btb_taken = 1'b1; btb_ret = 1'b1; ras_valid = 1'b1;
        ras_tgt = 32'h340; btb_tgt = 32'h500;
        #1;
        check("ret_ras_pc_next", pc_next, 32'h340);
        ras_valid = 1'b0;
        #1;
        check("ret_noras_pc_next", pc_next, 32'h500);
        clear_btb();
        #1;
        check("plain_pc_next", pc_next, 32'h204);

        // Redirect during a 3-cycle stall; newest target must win
        advance = 1'b0; redirect_valid = 1'b1; redirect_tgt = 32'h400;
        #1;
        check("stall_rd_pc_next", pc_next, 32'h400);
        tick();
        check("stall1_pc", pc, 32'h200);
        redirect_tgt = 32'h480;
        tick();
        check("stall2_pc", pc, 32'h200);
        tick();
        check("stall3_pc", pc, 32'h200);
        redirect_valid = 1'b0; redirect_tgt = 32'h0;
        #1;
        check("pend_pc_next", pc_next, 32'h480);
        check("stall_redirect_cnt", redirect_cnt, 32'd0);
        advance = 1'b1;
        tick();
        check("pend_applied_pc", pc, 32'h480);
        check("pend_cleared_pc_next", pc_next, 32'h484);
        check("pend_redirect_cnt", redirect_cnt, STATS ? 32'd1 : 32'd0);

        // Redirect coincident with a taken prediction: redirect wins
        redirect_valid = 1'b1; redirect_tgt = 32'h600;
        btb_hit = 1'b1; btb_taken = 1'b1; btb_tgt = 32'h200;
        #1;
        check("coinc_pc_next", pc_next, 32'h600);
        tick();
        redirect_valid = 1'b0; redirect_tgt = 32'h0;
        clear_btb();
        #1;
        check("coinc_pc", pc, 32'h600);
        check("coinc_pc_next_after", pc_next, 32'h604);
        check("coinc_redirect_cnt", redirect_cnt, STATS ? 32'd2 : 32'd0);
        check("coinc_pred_cnt", pred_cnt, STATS ? 32'd1 : 32'd0);

        // Reset mid-operation drops a pending redirect
        advance = 1'b0; redirect_valid = 1'b1; redirect_tgt = 32'h700;
        tick();
        redirect_valid = 1'b0; redirect_tgt = 32'h0;
        rst_n = 1'b0;
        tick();
        check("mid_rst_pc", pc, 32'h100);
        check("mid_rst_valid", {31'b0, valid_if}, 32'h0);
        check("mid_rst_redirect_cnt", redirect_cnt, 32'h0);
        check("mid_rst_pred_cnt", pred_cnt, 32'h0);
        rst_n = 1'b1; advance = 1'b1;
        tick();
        check("mid_rel_pc_next", pc_next, 32'h100);
        tick();
        check("mid_rel_pc", pc, 32'h100);
        check("mid_rel_pc_next2", pc_next, 32'h104);

        // BPRED=0: wrap at top of address space, BTB/RAS inputs ignored
        rst_n2 = 1'b1;
        tick();
        check("np_valid", {31'b0, valid_if2}, 32'h1);
        check("np_pc", pc2, 32'hFFFF_FFFC);
        check("np_pc_next", pc_next2, 32'h0);
        advance2 = 1'b1;
        rand_btb2();
        tick();
        check("np_wrap_pc", pc2, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            rand_btb2();
            #1;
            check("np_seq_pc_next", pc_next2, 32'(4 * i));
            tick();
            check("np_seq_pc", pc2, 32'(4 * i));
        end
        check("np_redirect_cnt", redirect_cnt2, 32'h0);
        check("np_pred_cnt", pred_cnt2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
